// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared types, constants and helpers for the pipeline hazard
//            controller (miss FSM state type, forwarding selects, result-select
//            encoding, forwarding-select helper).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    // Data-memory miss FSM states
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        MISS = 1'b1
    } miss_state_t;

    // Operand forwarding selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // resultsrcE encoding for a load
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // Forwarding select for one Execute source operand. Memory is the younger
    // producer, so it is checked first. x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
// ============================================================================
// Module   : hazard_perf_cnt
// Purpose  : Enable-driven performance counter that saturates at all-ones.
// Ports    : clk     - core clock
//            rst     - asynchronous active-high reset (clears the count)
//            i_en    - count this cycle
//            o_cnt   - current count, WIDTH bits
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller for the five-stage core: load-use
//            stall, taken-branch flush, operand forwarding, data-memory miss
//            stall FSM and a sticky miss-wait watchdog.
// Ports    : clk, rst                       - clock, async active-high reset
//            rs1D/rs2D                      - Decode source registers
//            rs1E/rs2E/rdE, resultsrcE      - Execute registers / result select
//            pcsrcE                         - taken branch/jump in Execute
//            rdM/rdW, regwriteM/regwriteW   - producers in Memory/Writeback
//            memreqM, memreadyM             - data-memory request / ready
//            stallF/D/E/M, flushD/E/W       - stage register controls
//            forwardAE/BE                   - operand forwarding selects
//            miss_timeout                   - sticky watchdog flag
//            lwstall_cnt/flush_cnt/miss_cnt - perf counters (macro only)
// Config   : HAZARD_PERF_CNT_EN - when defined, adds the three counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MISS_TIMEOUT = 256,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rs1D,
    input  logic [4:0]           rs2D,
    input  logic [4:0]           rs1E,
    input  logic [4:0]           rs2E,
    input  logic [4:0]           rdE,
    input  logic [1:0]           resultsrcE,
    input  logic                 pcsrcE,
    input  logic [4:0]           rdM,
    input  logic [4:0]           rdW,
    input  logic                 regwriteM,
    input  logic                 regwriteW,
    input  logic                 memreqM,
    input  logic                 memreadyM,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 stallE,
    output logic                 stallM,
    output logic                 flushD,
    output logic                 flushE,
    output logic                 flushW,
    output logic [1:0]           forwardAE,
    output logic [1:0]           forwardBE,
    output logic                 miss_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] lwstall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
`endif
);

    // Wait counter only needs to reach MISS_TIMEOUT, where it saturates
    localparam int c_WAIT_W = $clog2(MISS_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MISS_TIMEOUT);

    miss_state_t         r_state;
    miss_state_t         w_state_nxt;
    logic                w_memstall;
    logic                w_lwstall;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic                r_timeout;

    assign w_lwstall = (resultsrcE == RESULT_LOAD) && (rdE != 5'd0) &&
                       ((rdE == rs1D) || (rdE == rs2D));

    // ---------------------------------------------------------------- miss FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The stall is raised already in the RUN cycle that sees the miss, so the
    // pipeline freezes on the very access that missed.
    always_comb begin
        w_state_nxt = r_state;
        w_memstall  = 1'b0;
        case (r_state)
            RUN: begin
                if (memreqM && !memreadyM) begin
                    w_state_nxt = MISS;
                    w_memstall  = 1'b1;
                end
            end
            MISS: begin
                if (memreadyM) begin
                    w_state_nxt = RUN;
                end else begin
                    w_memstall = 1'b1;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // ------------------------------------------------------ stall/flush/forward
    // A miss freezes F..M and bubbles W; D/E flushes are suppressed so a
    // pending branch or load-use is re-evaluated once the miss releases.
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        forwardAE = fwd_sel(rs1E, rdM, regwriteM, rdW, regwriteW);
        forwardBE = fwd_sel(rs2E, rdM, regwriteM, rdW, regwriteW);
        if (rst) begin
            flushD    = 1'b1;
            flushE    = 1'b1;
            flushW    = 1'b1;
            forwardAE = FWD_RF;
            forwardBE = FWD_RF;
        end else if (w_memstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else begin
            stallF = w_lwstall;
            stallD = w_lwstall;
            flushD = pcsrcE;
            flushE = w_lwstall || pcsrcE;
        end
    end

    // ---------------------------------------------------------------- watchdog
    always_comb begin
        w_wait_nxt = '0;
        if (r_state == MISS) begin
            w_wait_nxt = (r_wait_cnt == c_WAIT_MAX) ? r_wait_cnt
                                                     : r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt == c_WAIT_MAX) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign miss_timeout = r_timeout;

    // ------------------------------------------------------- perf counters
`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(.WIDTH(CNT_WIDTH)) u_lwstall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_lwstall && !w_memstall),
        .o_cnt (lwstall_cnt)
    );

    hazard_perf_cnt #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (pcsrcE && !w_memstall),
        .o_cnt (flush_cnt)
    );

    hazard_perf_cnt #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_memstall),
        .o_cnt (miss_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl (MISS_TIMEOUT = 8).
//            Counter checks are compiled in with HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0]  resultsrcE;
    logic        pcsrcE, regwriteM, regwriteW, memreqM, memreadyM;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [1:0]  forwardAE, forwardBE;
    logic        miss_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lwstall_cnt, flush_cnt, miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    logic [6:0] ctl;
    assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};

    hazard_ctrl #(.MISS_TIMEOUT(8), .CNT_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1D         (rs1D),
        .rs2D         (rs2D),
        .rs1E         (rs1E),
        .rs2E         (rs2E),
        .rdE          (rdE),
        .resultsrcE   (resultsrcE),
        .pcsrcE       (pcsrcE),
        .rdM          (rdM),
        .rdW          (rdW),
        .regwriteM    (regwriteM),
        .regwriteW    (regwriteW),
        .memreqM      (memreqM),
        .memreadyM    (memreadyM),
        .stallF       (stallF),
        .stallD       (stallD),
        .stallE       (stallE),
        .stallM       (stallM),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushW       (flushW),
        .forwardAE    (forwardAE),
        .forwardBE    (forwardBE),
        .miss_timeout (miss_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .lwstall_cnt  (lwstall_cnt),
        .flush_cnt    (flush_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        resultsrcE = 2'b00; pcsrcE = 0; regwriteM = 0; regwriteW = 0;
        memreqM = 0; memreadyM = 0;
    endtask

    // Inputs change 1 time unit after posedge; outputs are checked 2 later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        regwriteM = 1; rdM = 5'd5; rs1E = 5'd5; rs2E = 5'd5; pcsrcE = 1;
        #2;
        checks++;
        if (ctl !== 7'b0000111) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 7'b0000111);
        end
        checks++;
        if ({forwardAE, forwardBE} !== 4'b0000) begin
            errors++; $display("FAIL reset_fwd: got %b expected %b", {forwardAE, forwardBE}, 4'b0000);
        end
        checks++;
        if (miss_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_timeout: got %b expected 0", miss_timeout);
        end
        tick();
        rst = 0;
        clear_inputs();
        tick();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        rdM = 5'd5; regwriteM = 1; rdW = 5'd5; regwriteW = 1; rs1E = 5'd5; rs2E = 5'd7;
        #2;
        checks++;
        if (forwardAE !== 2'b10 || forwardBE !== 2'b00) begin
            errors++; $display("FAIL fwd_mem_prio: got %b/%b expected 10/00", forwardAE, forwardBE);
        end
        rdM = 5'd0;
        #2;
        checks++;
        if (forwardAE !== 2'b01) begin
            errors++; $display("FAIL fwd_wb: got %b expected 01", forwardAE);
        end
        rs1E = 5'd0; rdW = 5'd0;
        #2;
        checks++;
        if (forwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_x0: got %b expected 00", forwardAE);
        end
        rdM = 5'd7; regwriteM = 0; rdW = 5'd7; regwriteW = 1;
        #2;
        checks++;
        if (forwardBE !== 2'b01) begin
            errors++; $display("FAIL fwdB_wb_no_we_m: got %b expected 01", forwardBE);
        end
        regwriteM = 1;
        #2;
        checks++;
        if (forwardBE !== 2'b10 || ctl !== 7'b0000000) begin
            errors++; $display("FAIL fwdB_mem: got %b ctl %b expected 10 ctl 0000000", forwardBE, ctl);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        resultsrcE = 2'b01; rdE = 5'd3; rs2D = 5'd3; rs1D = 5'd4;
        #2;
        checks++;
        if (ctl !== 7'b1100010) begin
            errors++; $display("FAIL lwstall_rs2: got %b expected %b", ctl, 7'b1100010);
        end
        tick();
        // Load has advanced to M; Execute now holds the bubble
        resultsrcE = 2'b00; rdE = 5'd0; rdM = 5'd3; regwriteM = 1; rs2E = 5'd3;
        #2;
        checks++;
        if (ctl !== 7'b0000000 || forwardBE !== 2'b10) begin
            errors++; $display("FAIL lwstall_release: got %b fwdB %b expected 0000000 fwdB 10", ctl, forwardBE);
        end
        clear_inputs();
        resultsrcE = 2'b01; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
        #2;
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++; $display("FAIL lwstall_x0: got %b expected 0000000", ctl);
        end
        resultsrcE = 2'b00; rdE = 5'd9; rs1D = 5'd9;
        #2;
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++; $display("FAIL no_load_no_stall: got %b expected 0000000", ctl);
        end
        resultsrcE = 2'b01;
        #2;
        checks++;
        if (ctl !== 7'b1100010) begin
            errors++; $display("FAIL lwstall_rs1: got %b expected %b", ctl, 7'b1100010);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        pcsrcE = 1;
        #2;
        checks++;
        if (ctl !== 7'b0000110) begin
            errors++; $display("FAIL branch_flush: got %b expected %b", ctl, 7'b0000110);
        end
        resultsrcE = 2'b01; rdE = 5'd6; rs1D = 5'd6;
        #2;
        checks++;
        if (ctl !== 7'b1100110) begin
            errors++; $display("FAIL branch_and_lwstall: got %b expected %b", ctl, 7'b1100110);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_miss();
        int stall_cycles;
        stall_cycles = 0;
        clear_inputs();
        memreqM = 1; memreadyM = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= 1) pcsrcE = 1;
            #2;
            checks++;
            if (ctl !== 7'b1111001) begin
                errors++; $display("FAIL miss_cycle%0d: got %b expected %b", i, ctl, 7'b1111001);
            end
            if (stallF === 1'b1) stall_cycles++;
            tick();
        end
        memreadyM = 1;
        #2;
        checks++;
        if (ctl !== 7'b0000110) begin
            errors++; $display("FAIL miss_release: got %b expected %b", ctl, 7'b0000110);
        end
        if (stallF === 1'b1) stall_cycles++;
        checks++;
        if (stall_cycles !== 4) begin
            errors++; $display("FAIL miss_length: got %0d expected 4", stall_cycles);
        end
        tick();
        clear_inputs();
        #2;
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++; $display("FAIL miss_after: got %b expected 0000000", ctl);
        end
        tick();
    endtask

    task automatic test_timeout();
        clear_inputs();
        memreqM = 1; memreadyM = 0;
        // Cycle 0 is the RUN cycle that detects the miss; cycles 1..9 are MISS
        for (int k = 0; k < 10; k++) begin
            #2;
            checks++;
            if (miss_timeout !== (k >= 9)) begin
                errors++; $display("FAIL timeout_cycle%0d: got %b expected %b", k, miss_timeout, (k >= 9));
            end
            tick();
        end
        memreadyM = 1;
        #2;
        checks++;
        if (stallF !== 1'b0 || miss_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_release: got stallF %b flag %b expected 0 1", stallF, miss_timeout);
        end
        tick();
        clear_inputs();
        tick();
        #2;
        checks++;
        if (miss_timeout !== 1'b1 || stallF !== 1'b0) begin
            errors++; $display("FAIL timeout_sticky: got flag %b stallF %b expected 1 0", miss_timeout, stallF);
        end
        // Reset in the middle of a new miss
        tick();
        memreqM = 1; memreadyM = 0;
        tick(); tick(); tick();
        rst = 1;
        #1;
        checks++;
        if (ctl !== 7'b0000111 || miss_timeout !== 1'b0) begin
            errors++; $display("FAIL rst_mid_miss: got %b flag %b expected 0000111 0", ctl, miss_timeout);
        end
        memreqM = 0;
        tick();
        rst = 0;
        #2;
        // memreadyM still low: a leftover MISS state would keep stalling
        checks++;
        if (ctl !== 7'b0000000 || miss_timeout !== 1'b0) begin
            errors++; $display("FAIL rst_to_run: got %b flag %b expected 0000000 0", ctl, miss_timeout);
        end
        tick();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            resultsrcE = 2'b01; rdE = 5'd2; rs1D = 5'd2;
            tick();
            clear_inputs();
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            pcsrcE = 1;
            tick();
            clear_inputs();
            tick();
        end
        memreqM = 1; memreadyM = 0;
        for (int i = 0; i < 5; i++) tick();
        memreadyM = 1;
        tick();
        clear_inputs();
        #2;
        checks++;
        if (lwstall_cnt !== 32'd3) begin
            errors++; $display("FAIL perf_lwstall: got %0d expected 3", lwstall_cnt);
        end
        checks++;
        if (flush_cnt !== 32'd2) begin
            errors++; $display("FAIL perf_flush: got %0d expected 2", flush_cnt);
        end
        checks++;
        if (miss_cnt !== 32'd5) begin
            errors++; $display("FAIL perf_miss: got %0d expected 5", miss_cnt);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_miss();
        test_timeout();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It sits beside the decode/execute pipeline register and drives that register's flush input, and the stall/flush inputs of the fetch and decode stages. It consumes the register indices that the decode/execute register carries forward. It combines load-use detection, taken-branch flushing, operand forwarding and a sequential data-memory miss stall FSM with a timeout watchdog.

## Interface
- MISS_TIMEOUT, 256: miss-wait cycles before `miss_timeout` sets; minimum 2.
- CNT_WIDTH, 32: width of each performance counter.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- rs1D, rs2D  in  5 each  source registers of the instruction in Decode
- rs1E, rs2E, rdE  in  5 each  source and destination registers in Execute
- resultsrcE  in  2  result select in Execute; 2'b01 = load
- pcsrcE  in  1  branch or jump taken in Execute
- rdM, rdW  in  5 each  destination registers in Memory and Writeback
- regwriteM, regwriteW  in  1 each  register write enables in Memory and Writeback
- memreqM  in  1  load or store active in Memory
- memreadyM  in  1  data memory access completes this cycle
- stallF, stallD, stallE, stallM  out  1 each  hold the stage register
- flushD, flushE, flushW  out  1 each  clear the stage register (insert bubble)
- forwardAE, forwardBE  out  2 each  operand source: 00 register file, 01 Writeback, 10 Memory
- miss_timeout  out  1  sticky watchdog flag
- lwstall_cnt, flush_cnt, miss_cnt  out  CNT_WIDTH each  performance counters; present only with the macro

## Operation
- Forwarding is combinational. forwardAE = 10 if regwriteM && rdM!=0 && rdM==rs1E. Otherwise 01 if regwriteW && rdW!=0 && rdW==rs1E. Otherwise 00. Memory has priority over Writeback. forwardBE is the same using rs2E.
- Load-use: lwstall = (resultsrcE==01) && rdE!=0 && (rdE==rs1D || rdE==rs2D).
- Miss FSM states are RUN and MISS.
  - RUN → MISS when memreqM && !memreadyM.
  - MISS → RUN when memreadyM.
  - memstall = (state==MISS && !memreadyM) || (state==RUN && memreqM && !memreadyM). The stall asserts in the first cycle of a miss, with no bubble lost.
- When memstall is 1:
  - stallF = stallD = stallE = stallM = 1.
  - flushW = 1.
  - flushD = flushE = 0. A pending pcsrcE or lwstall is held, not lost, and is acted on after release.
- When memstall is 0:
  - stallF = stallD = lwstall.
  - stallE = stallM = 0.
  - flushD = pcsrcE.
  - flushE = lwstall || pcsrcE.
  - flushW = 0.
- Simultaneous lwstall and pcsrcE: the flush wins for D. Both still assert flushE, and stallF/stallD also assert. The PC mux gives pcsrcE priority.
- Watchdog: a miss-wait counter clears in RUN and increments each MISS cycle, saturating. miss_timeout sets when the counter reaches MISS_TIMEOUT and stays set until rst. It does not change pipeline behaviour.
- Reset mid-miss: the FSM returns to RUN immediately. The miss-wait counter and any pending stall are discarded.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the registered state, with zero latency.
- State, the wait counter, miss_timeout and the perf counters update on posedge clk.
- While rst is high, forced outputs:
  - all stall* = 0
  - flushD = flushE = flushW = 1
  - forward* = 00
  - miss_timeout = 0
  - counters = 0
  - state = RUN
- A miss of N cycles (memreadyM low for N cycles after memreqM) stalls for exactly N cycles. The pipeline advances on the cycle memreadyM is 1.
- A load-use stall lasts exactly one cycle; in the next cycle the load has moved to M.

## Configuration
- HAZARD_PERF_CNT_EN defined: counters are present, each saturating at all-ones and cleared by rst.
  - lwstall_cnt += 1 per cycle with lwstall && !memstall.
  - flush_cnt += 1 per cycle with pcsrcE && !memstall.
  - miss_cnt += 1 per cycle with memstall.
- HAZARD_PERF_CNT_EN undefined: the counter ports and logic are absent. Behaviour is otherwise identical.

## Structure
- The shared package holds:
  - the state enum type (RUN, MISS)
  - forward constants FWD_RF=00, FWD_WB=01, FWD_MEM=10
  - RESULT_LOAD=2'b01
- Sub-module hazard_perf_cnt: one saturating, enable-driven counter of CNT_WIDTH, instantiated three times under the macro.

## Test plan
- rdM=5, regwriteM=1, rdW=5, regwriteW=1, rs1E=5 → forwardAE=10. Then rdM=0 → forwardAE=01. Then rs1E=0 with rdW=0 → 00.
- resultsrcE=01, rdE=3, rs2D=3 → stallF=stallD=flushE=1 for one cycle. With rdE=0 → no stall.
- pcsrcE=1 → flushD=flushE=1, no stalls. pcsrcE together with lwstall → flushD=1, flushE=1, stallF=1.
- memreqM=1, memreadyM low 4 cycles then high → all four stalls and flushW high for exactly 4 cycles. pcsrcE asserted during the miss → flushD held 0 until release, then 1.
- MISS_TIMEOUT=8, memreadyM held low 10 cycles → miss_timeout rises after the 8th MISS cycle and stays set after release. rst pulsed mid-miss → state RUN, flag 0.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls, 2 taken branches and a 5-cycle miss → lwstall_cnt=3, flush_cnt=2, miss_cnt=5.
